write_back_stage: RTL and testbench
===================================

// Module: write_back_stage
// PURPOSE
//   Final pipeline stage (MEM/WB register + result select) that drives the register-file write port
//   of instruction_decode: write_result, write_addr, register_write.
//   Selects ALU result, formatted load data or link address; retires instructions; detects halt.
// PARAMETERS
//   DRAIN_CYCLES  4  cycles spent in DRAIN after a halt retires, before halted asserts (1..15)
// PORTS
//   clk            in   1   rising-edge clock
//   reset          in   1   synchronous, active-high reset
//   valid_in       in   1   MEM stage presents a valid instruction this cycle
//   stall          in   1   hold the WB register; no capture, no retire
//   reg_write_in   in   1   instruction writes a register
//   mem_to_reg     in   1   1 = result from mem_data, 0 = from alu_result
//   link           in   1   jal/jalr: result = pc_in + 8 (overrides mem_to_reg)
//   load_type      in   3   0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu; 5-7 treated as lw
//   dest_addr      in   5   destination register number
//   alu_result     in   32  ALU output; [1:0] is the load byte offset
//   mem_data       in   32  aligned 32-bit word read from data memory
//   pc_in          in   32  PC of the instruction
//   halt_in        in   1   instruction is the halt word (32'hFFFFFFFF)
//   write_result   out  32  data to register file
//   write_addr     out  5   register-file write address
//   register_write out  1   register-file write enable
//   misaligned     out  1   sticky: halfword load with offset[0]=1 was seen
//   retired_count  out  32  number of retired instructions
//   halted         out  1   pipeline has drained after halt
// BEHAVIOUR
//   Reset: write_result=0, write_addr=0, register_write=0, misaligned=0, retired_count=0,
//     halted=0, state=RUN. Reset wins over every other input, in any state.
//   Latency: one cycle. Inputs sampled at posedge N appear on outputs after posedge N;
//     register file consumes them at posedge N+1. register_write is high for exactly one cycle/instr.
//   Capture (state RUN, valid_in=1, stall=0):
//     register_write <= reg_write_in & (dest_addr != 0) & ~bad_half & ~halt_in
//     write_addr <= dest_addr; retired_count <= retired_count + 1 (wraps 2^32-1 -> 0).
//   Bubble (valid_in=0, stall=0): register_write <= 0; other outputs hold.
//   stall=1: all outputs hold their values, except register_write <= 0 (no double write).
//   Result select: link -> pc_in + 8 (mod 2^32); else mem_to_reg -> load value; else alu_result.
//   Load formatting, little-endian, off = alu_result[1:0]:
//     lw: mem_data (off ignored). lb/lbu: byte mem_data[8*off+7 : 8*off], sign/zero extend.
//     lh/lhu: half mem_data[16*off[1]+15 : 16*off[1]], sign/zero extend.
//     bad_half = mem_to_reg & (lh|lhu) & off[0]: write suppressed, misaligned <= 1 (sticky until reset).
//   Writes to $0 never assert register_write; the instruction still retires.
//   State machine:
//     RUN    -> DRAIN on capture with halt_in=1 (halt counts as retired, no write); counter <= 0.
//     DRAIN  : inputs ignored, register_write=0; counter+1 per cycle (stall ignored);
//              after DRAIN_CYCLES cycles -> HALTED.
//     HALTED : halted=1; all inputs ignored, register_write=0; leave only by reset.
//   Simultaneous halt_in with reg_write_in: halt wins, no write.
// TESTING
//   addi $8 result: valid_in, reg_write_in, dest=8, alu_result=32'h0000_0005 -> next cycle
//     register_write=1, write_addr=8, write_result=5; following bubble -> register_write=0.
//   lb/lbu: mem_data=32'h80FF_7F01, off=3: lb -> FFFF_FF80, lbu -> 0000_0080;
//     lh off=2 -> FFFF_80FF; lhu off=1 -> no write, misaligned=1.
//   jal at pc_in=32'h0040_0010, dest=31 -> write_result=32'h0040_0018; pc_in=FFFF_FFFC -> 0000_0004.
//   dest=0 with reg_write_in=1 -> register_write=0, retired_count still increments.
//   stall held 3 cycles mid-stream -> register_write=0 throughout, count unchanged, outputs held.
//   halt_in -> no write; halted rises exactly DRAIN_CYCLES+1 cycles after capture edge;
//     later valid inputs ignored; reset during DRAIN or HALTED -> all outputs 0, state RUN.

Source files
------------

// File: rtl/write_back_stage.sv
// ----------------------------------------------------------------------------
// write_back_stage
//   Final pipeline stage: MEM/WB register plus result select. Drives the
//   register-file write port (write_result / write_addr / register_write),
//   formats load data, produces link addresses, counts retired instructions
//   and detects halt, after which the pipeline drains and then parks in
//   HALTED until reset.
//
// Parameters
//   DRAIN_CYCLES   cycles spent in DRAIN after a halt retires (1..15)
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   synchronous, active-high reset
//   valid_in        in   MEM stage presents a valid instruction
//   stall           in   hold the WB register (no capture, no retire)
//   reg_write_in    in   instruction writes a register
//   mem_to_reg      in   result comes from formatted load data
//   link            in   result is pc_in + 8 (overrides mem_to_reg)
//   load_type [2:0] in   0 lw, 1 lh, 2 lhu, 3 lb, 4 lbu, 5-7 lw
//   dest_addr [4:0] in   destination register
//   alu_result[31:0]in   ALU output; [1:0] is the load byte offset
//   mem_data  [31:0]in   aligned word read from data memory
//   pc_in     [31:0]in   PC of the instruction
//   halt_in         in   instruction is the halt word
//   write_result[31:0] out  data to register file
//   write_addr  [4:0]  out  register-file write address
//   register_write     out  register-file write enable (one cycle per instr)
//   misaligned         out  sticky: odd-offset halfword load seen
//   retired_count[31:0]out  retired instruction count (wraps)
//   halted             out  pipeline has drained after halt
// ----------------------------------------------------------------------------
module write_back_stage #(
    parameter int DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        stall,
    input  logic        reg_write_in,
    input  logic        mem_to_reg,
    input  logic        link,
    input  logic [2:0]  load_type,
    input  logic [4:0]  dest_addr,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_data,
    input  logic [31:0] pc_in,
    input  logic        halt_in,
    output logic [31:0] write_result,
    output logic [4:0]  write_addr,
    output logic        register_write,
    output logic        misaligned,
    output logic [31:0] retired_count,
    output logic        halted
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES);

    state_t      state, state_next;
    logic [3:0]  drain_cnt;
    logic        capture;
    logic [1:0]  offset;
    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] load_value;
    logic [31:0] selected;
    logic        is_half;
    logic        bad_half;

    assign capture  = (state == RUN) && valid_in && !stall;
    assign offset   = alu_result[1:0];
    assign byte_val = mem_data[{offset, 3'b000} +: 8];
    assign half_val = mem_data[{offset[1], 4'b0000} +: 16];
    assign is_half  = (load_type == 3'd1) || (load_type == 3'd2);
    // An odd-offset halfword load is dropped rather than written with garbage.
    assign bad_half = mem_to_reg && is_half && offset[0];

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned (which would infer a latch).
    always_comb begin
        load_value = mem_data;
        case (load_type)
            3'd1:    load_value = {{16{half_val[15]}}, half_val};
            3'd2:    load_value = {16'h0000, half_val};
            3'd3:    load_value = {{24{byte_val[7]}}, byte_val};
            3'd4:    load_value = {24'h000000, byte_val};
            default: load_value = mem_data;
        endcase
    end

    always_comb begin
        selected = alu_result;
        if (link)
            selected = pc_in + 32'd8;
        else if (mem_to_reg)
            selected = load_value;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (capture && halt_in) state_next = DRAIN;
            // Counter counts edges spent in DRAIN; leaving on the edge where it
            // already holds DRAIN_CYCLES puts halted high DRAIN_CYCLES+1 edges
            // after the halt was captured.
            DRAIN:   if (drain_cnt == DRAIN_LAST) state_next = HALTED;
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if (state == DRAIN)
                drain_cnt <= drain_cnt + 4'd1;
            else
                drain_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_result   <= 32'd0;
            write_addr     <= 5'd0;
            register_write <= 1'b0;
            misaligned     <= 1'b0;
            retired_count  <= 32'd0;
        end else begin
            // Write enable is a one-cycle pulse; bubbles, stalls, DRAIN and
            // HALTED all fall through to this default.
            register_write <= 1'b0;
            if (capture) begin
                write_result   <= selected;
                write_addr     <= dest_addr;
                register_write <= reg_write_in && (dest_addr != 5'd0)
                                  && !bad_half && !halt_in;
                retired_count  <= retired_count + 32'd1;
                if (bad_half)
                    misaligned <= 1'b1;
            end
        end
    end

    assign halted = (state == HALTED);

endmodule

// File: tb/tb_write_back_stage.sv
module tb_write_back_stage;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, stall, reg_write_in, mem_to_reg, link, halt_in;
    logic [2:0]  load_type;
    logic [4:0]  dest_addr;
    logic [31:0] alu_result, mem_data, pc_in;
    logic [31:0] write_result;
    logic [4:0]  write_addr;
    logic        register_write, misaligned, halted;
    logic [31:0] retired_count;

    write_back_stage #(.DRAIN_CYCLES(D)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .stall(stall),
        .reg_write_in(reg_write_in), .mem_to_reg(mem_to_reg), .link(link),
        .load_type(load_type), .dest_addr(dest_addr), .alu_result(alu_result),
        .mem_data(mem_data), .pc_in(pc_in), .halt_in(halt_in),
        .write_result(write_result), .write_addr(write_addr),
        .register_write(register_write), .misaligned(misaligned),
        .retired_count(retired_count), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    // Reference model: mode 0 running, 1 draining, 2 halted.
    int          m_mode;
    int          m_since_halt;
    logic [31:0] m_res, m_count;
    logic [4:0]  m_addr;
    logic        m_wr, m_mis, m_halted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] load_ref(input logic [2:0] lt, input logic [31:0] w,
                                             input logic [1:0] off);
        logic [31:0] b, h;
        b = (w >> (8 * off)) & 32'hFF;
        h = (w >> (16 * (off / 2))) & 32'hFFFF;
        case (lt)
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd2:    return h;
            3'd3:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd4:    return b;
            default: return w;
        endcase
    endfunction

    function automatic void model_step();
        logic bad;
        wr_t  t;
        m_wr = 1'b0;
        if (reset) begin
            m_mode = 0; m_since_halt = 0; m_res = 0; m_count = 0;
            m_addr = 0; m_mis = 0;
        end else if (m_mode == 0) begin
            if (valid_in && !stall) begin
                bad = mem_to_reg && (load_type == 3'd1 || load_type == 3'd2) && alu_result[0];
                m_count = m_count + 1;
                m_addr  = dest_addr;
                if (link)            m_res = pc_in + 32'd8;
                else if (mem_to_reg) m_res = load_ref(load_type, mem_data, alu_result[1:0]);
                else                 m_res = alu_result;
                if (bad) m_mis = 1'b1;
                m_wr = reg_write_in && (dest_addr != 0) && !bad && !halt_in;
                if (m_wr) begin
                    t.addr = m_addr; t.data = m_res;
                    exp_q.push_back(t);
                end
                if (halt_in) begin
                    m_mode = 1; m_since_halt = 0;
                end
            end
        end else if (m_mode == 1) begin
            m_since_halt++;
            if (m_since_halt == D + 1) m_mode = 2;
        end
        m_halted = (m_mode == 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("register_write", 32'(register_write), 32'(m_wr));
        check("write_addr",     32'(write_addr),     32'(m_addr));
        check("write_result",   write_result,        m_res);
        check("retired_count",  retired_count,       m_count);
        check("misaligned",     32'(misaligned),     32'(m_mis));
        check("halted",         32'(halted),         32'(m_halted));
    endtask

    task automatic drive(input logic v, input logic st, input logic rw, input logic m2r,
                         input logic lk, input logic [2:0] lt, input logic [4:0] d,
                         input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc, input logic h);
        valid_in = v; stall = st; reg_write_in = rw; mem_to_reg = m2r; link = lk;
        load_type = lt; dest_addr = d; alu_result = alu; mem_data = mem; pc_in = pc;
        halt_in = h;
    endtask

    task automatic drive_random(input bit allow_halt);
        drive(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0), $urandom_range(0, 1),
              $urandom_range(0, 1), ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
              5'($urandom_range(0, 31)), $urandom, $urandom, $urandom,
              allow_halt && ($urandom_range(0, 3) == 0));
    endtask

    // Scoreboard monitor: each write pulse pops the oldest expected write.
    always @(negedge clk) begin
        if (register_write === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: addr %0d data %h, none expected at %0t",
                         write_addr, write_result, $time);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("sb_addr", 32'(write_addr), 32'(e.addr));
                check("sb_data", write_result, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] saved_count;

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        check("reset_result", write_result, 32'd0);
        check("reset_count", retired_count, 32'd0);
        reset = 1'b0;

        // addi $8 = 5, then a bubble
        drive(1, 0, 1, 0, 0, 0, 8, 32'h5, 0, 0, 0);
        tick();
        check("addi_we", 32'(register_write), 32'd1);
        check("addi_addr", 32'(write_addr), 32'd8);
        check("addi_data", write_result, 32'd5);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("bubble_we", 32'(register_write), 32'd0);

        // load formatting
        drive(1, 0, 1, 1, 0, 3'd3, 9, 32'h3, 32'h80FF_7F01, 0, 0);
        tick();
        check("lb_off3", write_result, 32'hFFFF_FF80);
        drive(1, 0, 1, 1, 0, 3'd4, 10, 32'h3, 32'h80FF_7F01, 0, 0);
        tick();
        check("lbu_off3", write_result, 32'h0000_0080);
        drive(1, 0, 1, 1, 0, 3'd1, 11, 32'h2, 32'h80FF_7F01, 0, 0);
        tick();
        check("lh_off2", write_result, 32'hFFFF_80FF);
        drive(1, 0, 1, 1, 0, 3'd2, 12, 32'h1, 32'h80FF_7F01, 0, 0);
        tick();
        check("lhu_off1_we", 32'(register_write), 32'd0);
        check("lhu_off1_mis", 32'(misaligned), 32'd1);

        // jal link address, including wrap
        drive(1, 0, 1, 0, 1, 0, 31, 32'h1234, 0, 32'h0040_0010, 0);
        tick();
        check("jal_data", write_result, 32'h0040_0018);
        drive(1, 0, 1, 1, 1, 0, 31, 0, 32'hDEAD_BEEF, 32'hFFFF_FFFC, 0);
        tick();
        check("jal_wrap", write_result, 32'h0000_0004);

        // write to $0 retires without writing
        saved_count = retired_count;
        drive(1, 0, 1, 0, 0, 0, 0, 32'h77, 0, 0, 0);
        tick();
        check("r0_we", 32'(register_write), 32'd0);
        check("r0_count", retired_count, saved_count + 32'd1);

        // stall held three cycles with a valid instruction presented
        saved_count = retired_count;
        drive(1, 1, 1, 0, 0, 0, 20, 32'hABCD, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        check("stall_count", retired_count, saved_count);
        check("stall_addr", 32'(write_addr), 32'd0);
        drive(1, 0, 1, 0, 0, 0, 20, 32'hABCD, 0, 0, 0);
        tick();
        check("after_stall", write_result, 32'hABCD);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive_random(1'b0);
            tick();
        end

        // halt: no write, halted exactly D+1 edges after capture, inputs ignored
        drive(1, 0, 1, 0, 0, 0, 5, 32'h99, 0, 0, 1);
        tick();
        check("halt_we", 32'(register_write), 32'd0);
        saved_count = retired_count;
        for (int k = 1; k <= D + 6; k++) begin
            drive_random(1'b1);
            tick();
            check("halt_timing", 32'(halted), 32'(k >= D + 1));
        end
        check("halted_count_frozen", retired_count, saved_count);

        // reset from HALTED
        reset = 1'b1;
        drive(1, 0, 1, 0, 0, 0, 7, 32'h11, 0, 0, 0);
        tick();
        check("rst_halted_h", 32'(halted), 32'd0);
        check("rst_halted_cnt", retired_count, 32'd0);
        reset = 1'b0;

        // reset from DRAIN, then normal operation resumes
        drive(1, 0, 0, 0, 0, 0, 3, 32'h22, 0, 0, 1);
        tick();
        drive_random(1'b1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rst_drain_mis", 32'(misaligned), 32'd0);
        check("rst_drain_cnt", retired_count, 32'd0);
        reset = 1'b0;
        drive(1, 0, 1, 0, 0, 0, 8, 32'h5, 0, 0, 0);
        tick();
        check("resume_we", 32'(register_write), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
